// File: rtl/countdown_ctrl_if.sv
// countdown_ctrl_if: request/control and status bundle between a requesting agent and countdown_ctrl.
interface countdown_ctrl_if #(
    parameter int WIDTH      = 3,
    parameter int PRESCALE_W = 4
);
    logic                  req;
    logic [WIDTH-1:0]      load_val;
    logic [PRESCALE_W-1:0] prescale;
    logic                  pause;
    logic                  abort;
    logic                  ack;
    logic [WIDTH-1:0]      count;
    logic                  busy;
    logic                  done;

    modport master (
        output req, load_val, prescale, pause, abort,
        input  ack, count, busy, done
    );

    modport slave (
        input  req, load_val, prescale, pause, abort,
        output ack, count, busy, done
    );
endinterface

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: req/ack-loaded prescaled down counter with pause, abort and terminal done pulse.
// Define COUNTDOWN_CTRL_AUTO_RELOAD_EN to reload lat_load at terminal count and keep running.
module countdown_ctrl #(
    parameter int WIDTH      = 3,
    parameter int PRESCALE_W = 4
) (
    input logic             clk,
    input logic             reset,
    countdown_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t                state;
    logic [WIDTH-1:0]      count;
    logic [WIDTH-1:0]      lat_load;
    logic [PRESCALE_W-1:0] pre_cnt;
    logic [PRESCALE_W-1:0] lat_pre;
    logic                  ack;
    logic                  done;

    assign bus.ack   = ack;
    assign bus.done  = done;
    assign bus.count = count;
    assign bus.busy  = state != IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            lat_load <= '0;
            pre_cnt  <= '0;
            lat_pre  <= '0;
            ack      <= 1'b0;
            done     <= 1'b0;
        end else begin
            ack  <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: if (bus.req) begin
                    count    <= bus.load_val;
                    lat_load <= bus.load_val;
                    lat_pre  <= bus.prescale;
                    pre_cnt  <= '0;
                    ack      <= 1'b1;
                    state    <= RUN;
                end
                RUN: if (bus.abort) begin
                    state   <= IDLE;
                    count   <= '0;
                    pre_cnt <= '0;
                end else if (bus.pause) begin
                    state <= HOLD;
                end else if (pre_cnt == lat_pre) begin
                    pre_cnt <= '0;
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end else begin
                        done <= 1'b1;
`ifdef COUNTDOWN_CTRL_AUTO_RELOAD_EN
                        count <= lat_load;
`else
                        state <= IDLE;
`endif
                    end
                end else begin
                    pre_cnt <= pre_cnt + 1'b1;
                end
                HOLD: if (bus.abort) begin
                    state   <= IDLE;
                    count   <= '0;
                    pre_cnt <= '0;
                end else if (!bus.pause) begin
                    state <= RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl: scoreboard bench; expected {count,busy,ack,done} per cycle is queued, then popped at each falling edge.
module tb_countdown_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;
    logic [5:0] sb[$];
    logic [5:0] e;
    logic [5:0] obs;

    countdown_ctrl_if #(.WIDTH(3), .PRESCALE_W(4)) bus ();
    countdown_ctrl #(.WIDTH(3), .PRESCALE_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    assign obs = {bus.count, bus.busy, bus.ack, bus.done};

    always #5 clk = ~clk;

    function automatic void push(logic [2:0] c, logic b, logic a, logic d);
        sb.push_back({c, b, a, d});
    endfunction

    function automatic void start(logic [2:0] lv, logic [3:0] ps);
        bus.load_val = lv;
        bus.prescale = ps;
        bus.req = 1'b1;
    endfunction

    task automatic test_reset;
        #2 reset = 1'b1;
        #1 checks++;
        if (obs !== 6'b0) begin failures++; $display("FAIL reset_async: got %b exp %b", obs, 6'b0); end
        @(negedge clk); checks++;
        if (obs !== 6'b0) begin failures++; $display("FAIL reset_held: got %b exp %b", obs, 6'b0); end
        reset = 1'b0;
        @(negedge clk); checks++;
        if (obs !== 6'b0) begin failures++; $display("FAIL reset_idle: got %b exp %b", obs, 6'b0); end
    endtask

    task automatic test_reset_mid_run;
        start(3'd7, 4'd0);
        push(3'd7, 1, 1, 0); push(3'd6, 1, 0, 0); push(3'd5, 1, 0, 0);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk); e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL mid_run[%0d]: got %b exp %b", i, obs, e); end
            bus.req = 1'b0;
        end
        #2 reset = 1'b1;
        #1 checks++;
        if (obs !== 6'b0) begin failures++; $display("FAIL mid_run_reset: got %b exp %b", obs, 6'b0); end
        @(negedge clk) reset = 1'b0;
        repeat (3) push(3'd0, 0, 0, 0);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk); e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL mid_run_after[%0d]: got %b exp %b", i, obs, e); end
        end
    endtask

    task automatic test_abort_busy;
        start(3'd7, 4'd0);
        push(3'd7, 1, 1, 0);
        for (int k = 1; k <= 4; k++) push(3'(7 - k), 1, 0, 0);
        push(3'd3, 1, 0, 0); push(3'd3, 1, 0, 0);
        push(3'd0, 0, 0, 0); push(3'd0, 0, 0, 0); push(3'd0, 0, 0, 0);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk); e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL abort_busy[%0d]: got %b exp %b", i, obs, e); end
            bus.req   = (i == 1);
            bus.pause = (i >= 4 && i <= 6);
            bus.abort = (i == 6);
        end
    endtask

`ifdef COUNTDOWN_CTRL_AUTO_RELOAD_EN
    task automatic test_auto_reload;
        start(3'd1, 4'd0);
        push(3'd1, 1, 1, 0);
        for (int i = 1; i <= 6; i++) push((i % 2) ? 3'd0 : 3'd1, 1, 0, (i % 2) == 0);
        push(3'd0, 0, 0, 0); push(3'd0, 0, 0, 0);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk); e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL auto_reload[%0d]: got %b exp %b", i, obs, e); end
            bus.req   = (i < 5);
            bus.abort = (i == 6);
        end
    endtask
`else
    task automatic test_full;
        start(3'd7, 4'd0);
        push(3'd7, 1, 1, 0);
        for (int k = 1; k <= 7; k++) push(3'(7 - k), 1, 0, 0);
        push(3'd0, 0, 0, 1); push(3'd0, 0, 0, 0);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk); e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL full[%0d]: got %b exp %b", i, obs, e); end
            bus.req = 1'b0;
        end
    endtask

    task automatic test_prescaled;
        start(3'd2, 4'd2);
        push(3'd2, 1, 1, 0);
        for (int k = 1; k <= 8; k++) push(3'(2 - k / 3), 1, 0, 0);
        push(3'd0, 0, 0, 1); push(3'd0, 0, 0, 0);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk); e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL prescaled[%0d]: got %b exp %b", i, obs, e); end
            bus.req = 1'b0;
        end
    endtask

    task automatic test_pause;
        int k;
        start(3'd7, 4'd1);
        push(3'd7, 1, 1, 0);
        for (int i = 1; i <= 20; i++) begin
            k = (i < 7) ? i : (i < 12) ? 6 : i - 5;
            push(3'(7 - k / 2), 1, 0, 0);
        end
        push(3'd0, 0, 0, 1); push(3'd0, 0, 0, 0);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk); e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL pause[%0d]: got %b exp %b", i, obs, e); end
            bus.req   = 1'b0;
            bus.pause = (i >= 6 && i <= 9);
        end
    endtask

    task automatic test_back_to_back;
        start(3'd1, 4'd0);
        push(3'd1, 1, 1, 0); push(3'd0, 1, 0, 0); push(3'd0, 0, 0, 1);
        push(3'd1, 1, 1, 0); push(3'd0, 1, 0, 0); push(3'd0, 0, 0, 1);
        push(3'd0, 0, 0, 0);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk); e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL back_to_back[%0d]: got %b exp %b", i, obs, e); end
            bus.req = (i < 3);
        end
    endtask

    task automatic test_abort_terminal;
        start(3'd0, 4'd0);
        push(3'd0, 1, 1, 0); push(3'd0, 0, 0, 0); push(3'd0, 0, 0, 0);
        for (int i = 0; sb.size() > 0; i++) begin
            @(negedge clk); e = sb.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL abort_terminal[%0d]: got %b exp %b", i, obs, e); end
            bus.req   = 1'b0;
            bus.abort = (i == 0);
        end
    endtask
`endif

    initial begin
        bus.req = 1'b0;
        bus.load_val = '0;
        bus.prescale = '0;
        bus.pause = 1'b0;
        bus.abort = 1'b0;
        test_reset();
        test_reset_mid_run();
        test_abort_busy();
`ifdef COUNTDOWN_CTRL_AUTO_RELOAD_EN
        test_auto_reload();
`else
        test_full();
        test_prescaled();
        test_pause();
        test_back_to_back();
        test_abort_terminal();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Sequencer for the team's WIDTH-bit down counter. It accepts a countdown request through a req/ack handshake and loads the start value. It then decrements the count once per prescaled tick and supports pause and abort. A one-cycle done pulse marks terminal count. It sits between a requesting agent (timer/sequencer logic) and the counter datapath, and owns the counter's load, enable and terminal handling.

## Interface

**Parameters**
- WIDTH, default 3: counter width; the default gives mod-8 behaviour.
- PRESCALE_W, default 4: width of the prescale divider.

**Ports**
- clk, input, 1: single clock; all state changes on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- req, input, 1: countdown request. Held with load_val and prescale stable until ack.
- load_val, input, WIDTH: start value, latched on accept.
- prescale, input, PRESCALE_W: cycles per tick minus 1, latched on accept.
- pause, input, 1: freezes the countdown while high.
- abort, input, 1: cancels the active countdown.
- ack, output, 1: one-cycle pulse; request accepted.
- count, output, WIDTH: current count value.
- busy, output, 1: high when state is not IDLE.
- done, output, 1: one-cycle pulse at terminal count.

## Operation

- States: IDLE, RUN, HOLD. Internal registers: pre_cnt (PRESCALE_W), lat_load (WIDTH), lat_pre (PRESCALE_W).
- **IDLE**
  - At an edge with req=1: count<=load_val, lat_load<=load_val, lat_pre<=prescale, pre_cnt<=0, ack<=1, go to RUN.
  - With req=0: outputs hold; count keeps its last value.
- **RUN**
  - abort=1 has top priority: go to IDLE, count<=0, pre_cnt<=0, no done.
  - Else pause=1: go to HOLD with no tick and pre_cnt unchanged.
  - Else if pre_cnt==lat_pre, the cycle is a tick: pre_cnt<=0.
  - Otherwise pre_cnt<=pre_cnt+1.
- **Tick**
  - If count!=0: count<=count-1.
  - If count==0 (terminal): done<=1 and apply terminal handling (see Configuration).
- **HOLD**
  - abort=1: same as in RUN.
  - pause=1: count and pre_cnt hold.
  - pause=0: return to RUN; counting resumes on the next edge.
- Requests arriving while busy=1 are ignored; no ack is issued. The requester keeps req high and is accepted after return to IDLE.
- Arithmetic is unsigned modulo 2^WIDTH. count never underflows; 0 is terminal.
- busy is decoded from the state register.
- ack and done are registered and are never high for two consecutive cycles from the same event.

## Timing

- Reset (asynchronous, immediate): state IDLE, count=0, pre_cnt=0, lat_load=0, lat_pre=0, ack=0, busy=0, done=0.
- Reset mid-operation aborts silently; no done pulse.
- Accept latency: ack is high in the cycle after the edge that samples req=1. busy rises in the same cycle.
- The first tick occurs lat_pre+1 edges after the accept edge.
- A countdown with no pause takes (load_val+1)·(prescale+1) edges from the accept edge to done.
- Without reload, done and busy=0 appear on the same edge. A req held high is accepted on the following edge.
- abort and pause asserted together: abort wins.
- Terminal tick coinciding with abort: abort wins, no done.

## Configuration

- Macro: COUNTDOWN_CTRL_AUTO_RELOAD_EN.
- **Defined:** a terminal tick reloads count<=lat_load, pre_cnt<=0, pulses done and stays in RUN. The block runs periodically until abort or reset. req is ignored while running.
- **Not defined:** a terminal tick pulses done, leaves count=0 and returns to IDLE.

## Test plan

- Reset mid-run:
  - Stimulus: load_val=7, prescale=0; assert reset while count=5, between edges.
  - Response: count=0, busy=0, ack=0, done=0 immediately; no done afterwards.
- Full countdown:
  - Stimulus: load_val=7, prescale=0.
  - Response: ack pulse; count 7,6,5,4,3,2,1,0 on consecutive cycles; done pulse and busy=0 on the 8th edge after ack.
- Prescaled countdown:
  - Stimulus: load_val=2, prescale=2.
  - Response: count changes every 3 cycles (2→1→0); done pulses 9 edges after the accept edge.
- Pause and resume:
  - Stimulus: load_val=7, prescale=1; pause high for 4 cycles at count=4.
  - Response: count held at 4 with pre_cnt frozen; after release, the total countdown is extended by exactly 4+1 cycles.
- Abort and busy rejection:
  - Stimulus: abort during HOLD at count=3.
  - Response: IDLE, count=0, no done.
  - Stimulus: req pulsed while busy.
  - Response: no ack.
- Auto-reload (COUNTDOWN_CTRL_AUTO_RELOAD_EN defined):
  - Stimulus: load_val=1, prescale=0.
  - Response: count 1,0,1,0…; done pulses every 2 cycles; busy stays 1 until abort.
